// File: rtl/boot_sequencer.sv
// Reset and boot-phase sequencer: walks the loader, memories, UART and core through
// power-on, program load, settle, run, halt and loader-fault phases.
module boot_sequencer #(
   parameter int POR_CYCLES    = 15,
   parameter int SETTLE_CYCLES = 4,
   parameter int LOAD_TIMEOUT  = 0,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pl_completed,
   input  logic       core_halted,
   input  logic       reload_req,
   output logic       pl_reset,
   output logic       inst_mem_reset,
   output logic       uart_reset,
   output logic       core_reset,
   output logic       main_mem_reset,
   output logic [2:0] phase,
   output logic       fault,
   output logic [7:0] boot_count
);

   typedef enum logic [2:0] {
      ST_POR    = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_HALTED = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] CNT_ZERO   = COUNT_WIDTH'(0);
   localparam logic [COUNT_WIDTH-1:0] POR_LOAD   = COUNT_WIDTH'(POR_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] SETL_LOAD  = COUNT_WIDTH'(SETTLE_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] TMO_LOAD   = COUNT_WIDTH'(LOAD_TIMEOUT);
   localparam bit                     TIMEOUT_EN = (LOAD_TIMEOUT != 0);
   localparam bit                     SKIP_SETL  = (SETTLE_CYCLES == 0);

   state_t                 state_r;
   state_t                 state_next_s;
   logic [COUNT_WIDTH-1:0] cnt_r;
   logic [COUNT_WIDTH-1:0] cnt_next_s;

   // Reset vector per phase, ordered {pl, inst_mem, uart, core, main_mem}.
   function automatic logic [4:0] resets_for(input state_t s);
      logic [4:0] r;
      case (s)
         ST_POR:    r = 5'b11111;
         ST_LOAD:   r = 5'b00011;
         ST_SETTLE: r = 5'b00011;
         ST_RUN:    r = 5'b00000;
         ST_HALTED: r = 5'b00000;
         ST_FAULT:  r = 5'b10011;
         default:   r = 5'b11111;
      endcase
      return r;
   endfunction

   // Next-state and phase-counter logic; the counter reloads on every state entry.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         ST_POR: begin
            if (cnt_r == CNT_ONE) begin
               state_next_s = ST_LOAD;
               cnt_next_s   = TMO_LOAD;
            end else begin
               cnt_next_s = cnt_r - CNT_ONE;
            end
         end
         ST_LOAD: begin
            // Completion is checked first so it wins over a same-cycle timeout.
            if (pl_completed) begin
               if (SKIP_SETL) begin
                  state_next_s = ST_RUN;
                  cnt_next_s   = CNT_ZERO;
               end else begin
                  state_next_s = ST_SETTLE;
                  cnt_next_s   = SETL_LOAD;
               end
            end else if (TIMEOUT_EN && (cnt_r == CNT_ONE)) begin
               state_next_s = ST_FAULT;
               cnt_next_s   = CNT_ZERO;
            end else if (TIMEOUT_EN) begin
               cnt_next_s = cnt_r - CNT_ONE;
            end else begin
               cnt_next_s = cnt_r;
            end
         end
         ST_SETTLE: begin
            if (cnt_r == CNT_ONE) begin
               state_next_s = ST_RUN;
               cnt_next_s   = CNT_ZERO;
            end else begin
               cnt_next_s = cnt_r - CNT_ONE;
            end
         end
         ST_RUN: begin
            if (reload_req) begin
               state_next_s = ST_POR;
               cnt_next_s   = POR_LOAD;
            end else if (core_halted) begin
               state_next_s = ST_HALTED;
               cnt_next_s   = CNT_ZERO;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_HALTED, ST_FAULT: begin
            if (reload_req) begin
               state_next_s = ST_POR;
               cnt_next_s   = POR_LOAD;
            end else begin
               state_next_s = state_r;
            end
         end
         default: begin
            state_next_s = ST_POR;
            cnt_next_s   = POR_LOAD;
         end
      endcase
   end

   // State, counter and registered output decode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r        <= ST_POR;
         cnt_r          <= POR_LOAD;
         pl_reset       <= 1'b1;
         inst_mem_reset <= 1'b1;
         uart_reset     <= 1'b1;
         core_reset     <= 1'b1;
         main_mem_reset <= 1'b1;
         fault          <= 1'b0;
         boot_count     <= 8'd0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         {pl_reset, inst_mem_reset, uart_reset, core_reset, main_mem_reset} <= resets_for(state_next_s);
         fault   <= (state_next_s == ST_FAULT);
         if ((state_next_s == ST_RUN) && (state_r != ST_RUN) && (boot_count != 8'hFF)) begin
            boot_count <= boot_count + 8'd1;
         end else begin
            boot_count <= boot_count;
         end
      end
   end

   assign phase = state_r;

endmodule
